// File: rtl/pcs_am_pkg.sv
// Shared definitions for the 100GBASE-R lane reorder block.
// Contents: alignment-marker table {M0,M1,M2} for the 20 PCS lanes,
// control sync header value, reorder FSM state encoding and the tagged
// per-lane payload layout produced by the deskew stage.
package pcs_am_pkg;

    localparam int unsigned N_AM = 20;
    localparam logic [1:0]  SH_CTRL = 2'b10;

    // {M0,M1,M2} per logical PCS lane, 100GBASE-R.
    localparam logic [23:0] AM_TABLE [N_AM] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef enum logic [1:0] {
        WAIT_DESKEW = 2'd0,
        CAPTURE     = 2'd1,
        CONFIRM     = 2'd2,
        LOCKED      = 2'd3
    } state_e;

    // One tagged lane as delivered by deskew: start tag, sync header, payload.
    typedef struct packed {
        logic        tag;
        logic [1:0]  sh;
        logic [63:0] payload;
    } tagged_lane_t;

endpackage

// File: rtl/lane_reorder_if.sv
// Data bus between deskew, lane_reorder and AM removal.
//   i_valid / i_data : tagged lanes from deskew (lane 0 in the MSBs)
//   o_data / o_valid / o_am_flag : reordered blocks (logical lane 0 in the MSBs)
// Modports: master = upstream/downstream environment, slave = lane_reorder.
interface lane_reorder_if #(
    parameter int unsigned N_LANES      = 20,
    parameter int unsigned NB_DATA      = 66,
    parameter int unsigned NB_FIFO_DATA = 67
);
    logic                            i_valid;
    logic [NB_FIFO_DATA*N_LANES-1:0] i_data;
    logic [NB_DATA*N_LANES-1:0]      o_data;
    logic                            o_am_flag;
    logic                            o_valid;

    modport master (
        output i_valid, i_data,
        input  o_data, o_am_flag, o_valid
    );

    modport slave (
        input  i_valid, i_data,
        output o_data, o_am_flag, o_valid
    );
endinterface

// File: rtl/am_id_decoder.sv
// Combinational AM lane-ID decoder for one tagged lane.
//   lane_i    : tagged lane {tag, sync header, payload}
//   id_c      : logical lane ID whose {M0,M1,M2} matches payload[63:40]
//   matched_c : a table entry matched and the sync header is control
module am_id_decoder
    import pcs_am_pkg::*;
#(
    parameter int unsigned N_LANES = 20,
    parameter int unsigned NB_ID   = 5
) (
    input  tagged_lane_t     lane_i,
    output logic [NB_ID-1:0] id_c,
    output logic             matched_c
);

    logic unused_c;
    assign unused_c = ^{lane_i.tag, lane_i.payload[39:0]};

    // Table entries are distinct, so at most one k can match.
    always_comb begin
        id_c      = '0;
        matched_c = 1'b0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if (lane_i.payload[63:40] == AM_TABLE[k]) begin
                id_c      = NB_ID'(k);
                matched_c = 1'b1;
            end
        end
        if (lane_i.sh != SH_CTRL) begin
            matched_c = 1'b0;
        end
    end

endmodule

// File: rtl/lane_reorder.sv
// PCS lane reorder: learns the physical-to-logical lane map from alignment
// markers, confirms it over consecutive AM sets, then emits blocks in
// logical lane order with one cycle of latency.
// Ports:
//   i_clock, i_reset (async, active low), i_enable (global hold),
//   i_deskew_done    : input alignment level from deskew
//   bus (slave)      : i_valid/i_data in, o_data/o_valid/o_am_flag out
//   o_reorder_done   : high while LOCKED
//   o_id_error       : one-cycle pulse on a bad or mismatching AM set
//   o_lane_map       : current map, logical lane 0 in the MSBs
//                      (present only with LANE_REORDER_MAP_OUT_EN defined)
module lane_reorder
    import pcs_am_pkg::*;
#(
    parameter int unsigned N_LANES      = 20,
    parameter int unsigned NB_DATA      = 66,
    parameter int unsigned NB_FIFO_DATA = 67,
    parameter int unsigned NB_ID        = 5,
    parameter int unsigned N_CONFIRM    = 2,
    parameter int unsigned MAX_MISS     = 3
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_deskew_done,
    lane_reorder_if.slave            bus,
    output logic                     o_reorder_done,
`ifdef LANE_REORDER_MAP_OUT_EN
    output logic [NB_ID*N_LANES-1:0] o_lane_map,
`endif
    output logic                     o_id_error
);

    localparam int unsigned CW = $clog2(N_CONFIRM + 1);
    localparam int unsigned MW = $clog2(MAX_MISS + 1);
    localparam logic [CW-1:0] CONF_MAX = CW'(N_CONFIRM);
    localparam logic [MW-1:0] MISS_MAX = MW'(MAX_MISS);

    tagged_lane_t                   lane_c [N_LANES];
    logic [NB_ID-1:0]               id_c   [N_LANES];
    logic [N_LANES-1:0]             tag_c, matched_c, seen_c;
    logic [N_LANES-1:0][NB_ID-1:0]  cand_c, map_q, map_d;

    state_e          state_q, state_d;
    logic [CW-1:0]   confirm_q, confirm_d, confirm_inc_c;
    logic [MW-1:0]   miss_q, miss_d, miss_inc_c;

    logic am_evt_c, partial_c, set_ok_c, good_c, bad_c, same_c;

    logic [NB_DATA*N_LANES-1:0] data_q, data_d, reorder_c;
    logic valid_q, valid_d, am_q, am_d, done_q, done_d, err_q, err_d;

    // Split the tagged bus into lanes; physical lane 0 sits in the MSBs.
    always_comb begin
        for (int unsigned p = 0; p < N_LANES; p++) begin
            lane_c[p] = tagged_lane_t'(bus.i_data[NB_FIFO_DATA*(N_LANES-p)-1 -: NB_FIFO_DATA]);
            tag_c[p]  = lane_c[p].tag;
        end
    end

    for (genvar p = 0; p < N_LANES; p++) begin : g_dec
        am_id_decoder #(
            .N_LANES (N_LANES),
            .NB_ID   (NB_ID)
        ) u_dec (
            .lane_i    (lane_c[p]),
            .id_c      (id_c[p]),
            .matched_c (matched_c[p])
        );
    end

    // Candidate map (logical -> physical) and ID coverage of this set.
    always_comb begin
        seen_c = '0;
        cand_c = '0;
        for (int unsigned p = 0; p < N_LANES; p++) begin
            for (int unsigned k = 0; k < N_LANES; k++) begin
                if (matched_c[p] && (id_c[p] == NB_ID'(k))) begin
                    seen_c[k] = 1'b1;
                    cand_c[k] = NB_ID'(p);
                end
            end
        end
    end

    // All lanes matched and every ID seen implies a permutation.
    assign set_ok_c  = (&matched_c) & (&seen_c);
    assign am_evt_c  = bus.i_valid & i_enable & (&tag_c);
    assign partial_c = bus.i_valid & i_enable & (|tag_c) & ~(&tag_c);
    assign good_c    = am_evt_c & set_ok_c;
    assign bad_c     = (am_evt_c & ~set_ok_c) | partial_c;
    assign same_c    = (cand_c == map_q);

    assign confirm_inc_c = (confirm_q == CONF_MAX) ? confirm_q : confirm_q + CW'(1);
    assign miss_inc_c    = (miss_q == MISS_MAX)    ? miss_q    : miss_q + MW'(1);

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= WAIT_DESKEW;
        end else if (i_enable) begin
            state_q <= state_d;
        end
    end

    // Next-state, map and counter update.
    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        miss_d    = miss_q;
        map_d     = map_q;
        if (!i_deskew_done) begin
            state_d   = WAIT_DESKEW;
            confirm_d = '0;
            miss_d    = '0;
        end else begin
            case (state_q)
                WAIT_DESKEW: state_d = CAPTURE;
                CAPTURE: begin
                    if (good_c) begin
                        map_d     = cand_c;
                        confirm_d = CW'(1);
                        miss_d    = '0;
                        state_d   = (CW'(1) >= CONF_MAX) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (good_c && same_c) begin
                        confirm_d = confirm_inc_c;
                        if (confirm_inc_c >= CONF_MAX) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (good_c) begin
                        map_d     = cand_c;
                        confirm_d = CW'(1);
                    end else if (bad_c) begin
                        state_d   = CAPTURE;
                        confirm_d = '0;
                    end
                end
                LOCKED: begin
                    // Map is frozen here; mismatching sets only count misses.
                    if (good_c && same_c) begin
                        miss_d = '0;
                    end else if (good_c || bad_c) begin
                        miss_d = miss_inc_c;
                        if (miss_inc_c >= MISS_MAX) begin
                            state_d   = CAPTURE;
                            miss_d    = '0;
                            confirm_d = '0;
                        end
                    end
                end
                default: state_d = WAIT_DESKEW;
            endcase
        end
    end

    // Logical lane k takes the block of physical lane map_q[k].
    always_comb begin
        reorder_c = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            reorder_c[NB_DATA*(N_LANES-k)-1 -: NB_DATA] =
                NB_DATA'({lane_c[map_q[k]].sh, lane_c[map_q[k]].payload});
        end
    end

    // Output next values; done follows state_d so it drops with the transition.
    always_comb begin
        err_d   = 1'b0;
        valid_d = 1'b0;
        am_d    = am_evt_c;
        done_d  = (state_d == LOCKED);
        data_d  = data_q;
        if (i_deskew_done) begin
            case (state_q)
                CAPTURE, CONFIRM: err_d = bad_c;
                LOCKED:           err_d = bad_c | (good_c & ~same_c);
                default:          err_d = 1'b0;
            endcase
        end
        if (state_q == LOCKED) begin
            valid_d = bus.i_valid;
            if (bus.i_valid) begin
                data_d = reorder_c;
            end
        end
    end

    // Map, counters and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            confirm_q <= '0;
            miss_q    <= '0;
            map_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            am_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (i_enable) begin
            confirm_q <= confirm_d;
            miss_q    <= miss_d;
            map_q     <= map_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            am_q      <= am_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_am_flag   = am_q;
    assign o_reorder_done  = done_q;
    assign o_id_error      = err_q;

`ifdef LANE_REORDER_MAP_OUT_EN
    // Export the map register, logical lane 0 field in the MSBs.
    always_comb begin
        o_lane_map = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            o_lane_map[NB_ID*(N_LANES-k)-1 -: NB_ID] = map_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_lane_reorder.sv
// Directed self-checking bench for lane_reorder.
module tb_lane_reorder;

    localparam int N   = 20;
    localparam int NBF = 67;
    localparam int NBD = 66;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b1;
    logic deskew = 1'b0;
    logic done, id_err;

    int checks = 0;
    int errors = 0;

    lane_reorder_if #(.N_LANES(N), .NB_DATA(NBD), .NB_FIFO_DATA(NBF)) bus ();

    lane_reorder dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_enable       (enable),
        .i_deskew_done  (deskew),
        .bus            (bus),
        .o_reorder_done (done),
        .o_id_error     (id_err)
    );

    always #5 clk = ~clk;

    logic [23:0] am_tab [N] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    // Physical lane p carries the AM of logical ID map_id[p].
    int map_id [N];

    function automatic logic [NBF-1:0] am_block(input int id);
        return {1'b1, 2'b10, am_tab[id], 40'h0};
    endfunction

    function automatic logic [NBD-1:0] data_block(input int p, input int seed);
        return {2'b01, 32'(seed), 32'(p) ^ 32'hA5A5_0000};
    endfunction

    // Expected reordered output for data_block payloads under map_id.
    function automatic logic [NBD*N-1:0] exp_data(input int seed);
        logic [NBD*N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            for (int p = 0; p < N; p++)
                if (map_id[p] == k) r[NBD*(N-k)-1 -: NBD] = data_block(p, seed);
        return r;
    endfunction

    function automatic logic [NBD-1:0] out_lane(input int k);
        return bus.o_data[NBD*(N-k)-1 -: NBD];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_am();
        for (int p = 0; p < N; p++) bus.i_data[NBF*(N-p)-1 -: NBF] = am_block(map_id[p]);
        bus.i_valid = 1'b1;
    endtask

    // AM set with lane 5's M0 inverted, so lane 5 matches nothing.
    task automatic drive_am_bad();
        logic [NBF-1:0] b;
        drive_am();
        b = am_block(map_id[5]);
        b[63:56] = ~b[63:56];
        bus.i_data[NBF*(N-5)-1 -: NBF] = b;
    endtask

    task automatic drive_data(input int seed);
        for (int p = 0; p < N; p++) bus.i_data[NBF*(N-p)-1 -: NBF] = {1'b0, data_block(p, seed)};
        bus.i_valid = 1'b1;
    endtask

    task automatic set_identity();
        for (int p = 0; p < N; p++) map_id[p] = p;
    endtask

    task automatic go_capture();
        bus.i_valid = 1'b0;
        deskew = 1'b0;
        tick();
        deskew = 1'b1;
        tick();
    endtask

    task automatic lock_current();
        go_capture();
        drive_am(); tick();
        drive_am(); tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        tick(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", id_err); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        checks++; if (bus.o_am_flag !== 1'b0) begin errors++; $display("FAIL reset_am: got %b want 0", bus.o_am_flag); end
        checks++; if (bus.o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.o_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        set_identity();
        go_capture();
        drive_am(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ident_done_1st: got %b want 0", done); end
        checks++; if (bus.o_am_flag !== 1'b1) begin errors++; $display("FAIL ident_am_flag: got %b want 1", bus.o_am_flag); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL ident_valid_unlocked: got %b want 0", bus.o_valid); end
        drive_am(); tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ident_done_2nd: got %b want 1", done); end
        checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL ident_err: got %b want 0", id_err); end
        drive_data(1); tick();
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL ident_valid: got %b want 1", bus.o_valid); end
        checks++; if (out_lane(0) !== {2'b01, 32'd1, 32'hA5A5_0000}) begin errors++; $display("FAIL ident_lane0: got %h want %h", out_lane(0), {2'b01, 32'd1, 32'hA5A5_0000}); end
        checks++; if (bus.o_data !== exp_data(1)) begin errors++; $display("FAIL ident_data1: got %h want %h", bus.o_data, exp_data(1)); end
        drive_data(2); tick();
        checks++; if (bus.o_data !== exp_data(2)) begin errors++; $display("FAIL ident_data2: got %h want %h", bus.o_data, exp_data(2)); end
        checks++; if (bus.o_am_flag !== 1'b0) begin errors++; $display("FAIL ident_am_clear: got %b want 0", bus.o_am_flag); end
    endtask

    task automatic test_swap();
        set_identity();
        map_id[0] = 7;
        map_id[7] = 0;
        lock_current();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL swap_done: got %b want 1", done); end
        drive_data(3);
        bus.i_data[NBF*(N-7)-1 -: NBF] = {1'b0, 66'h2_DEAD_BEEF_0000_0001};
        tick();
        checks++; if (out_lane(0) !== 66'h2_DEAD_BEEF_0000_0001) begin errors++; $display("FAIL swap_lane0: got %h want %h", out_lane(0), 66'h2_DEAD_BEEF_0000_0001); end
        checks++; if (out_lane(7) !== data_block(0, 3)) begin errors++; $display("FAIL swap_lane7: got %h want %h", out_lane(7), data_block(0, 3)); end
        checks++; if (out_lane(12) !== data_block(12, 3)) begin errors++; $display("FAIL swap_lane12: got %h want %h", out_lane(12), data_block(12, 3)); end
        drive_data(4); tick();
        checks++; if (bus.o_data !== exp_data(4)) begin errors++; $display("FAIL swap_data: got %h want %h", bus.o_data, exp_data(4)); end
    endtask

    task automatic test_duplicate();
        set_identity();
        map_id[4] = 3;
        go_capture();
        drive_am(); tick();
        checks++; if (id_err !== 1'b1) begin errors++; $display("FAIL dup_err: got %b want 1", id_err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dup_done: got %b want 0", done); end
        drive_data(0); tick();
        checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL dup_err_pulse: got %b want 0", id_err); end
        drive_am(); tick();
        checks++; if (id_err !== 1'b1) begin errors++; $display("FAIL dup_err_again: got %b want 1", id_err); end
        map_id[4] = 4;
        drive_am(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dup_recover_1st: got %b want 0", done); end
        drive_am(); tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dup_recover_2nd: got %b want 1", done); end
        bus.i_valid = 1'b0;
    endtask

    task automatic test_loss();
        int pulses;
        set_identity();
        lock_current();
        drive_am_bad(); tick();
        checks++; if (id_err !== 1'b1) begin errors++; $display("FAIL loss_err1: got %b want 1", id_err); end
        drive_data(0); tick();
        checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL loss_err_gap: got %b want 0", id_err); end
        drive_am_bad(); tick();
        drive_am(); tick();
        checks++; if (id_err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL loss_good_between: got err=%b done=%b want err=0 done=1", id_err, done); end
        pulses = 0;
        drive_am_bad(); tick(); pulses += int'(id_err);
        drive_am_bad(); tick(); pulses += int'(id_err);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL loss_done_after2: got %b want 1", done); end
        drive_am_bad(); tick(); pulses += int'(id_err);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL loss_done_after3: got %b want 0", done); end
        checks++; if (pulses != 3) begin errors++; $display("FAIL loss_pulses: got %0d want 3", pulses); end
        drive_data(9); tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL loss_valid: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_midstream();
        set_identity();
        lock_current();
        drive_data(5); tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (done !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_am_flag !== 1'b0 || id_err !== 1'b0) begin
            errors++; $display("FAIL async_reset_ctrl: got done=%b valid=%b am=%b err=%b want 0000", done, bus.o_valid, bus.o_am_flag, id_err); end
        checks++; if (bus.o_data !== '0) begin errors++; $display("FAIL async_reset_data: got %h want 0", bus.o_data); end
        tick();
        rst_n = 1'b1;
        lock_current();
        drive_data(6); tick();
        deskew = 1'b0;
        drive_data(7); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL deskew_drop_done: got %b want 0", done); end
        tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL deskew_drop_valid: got %b want 0", bus.o_valid); end
        deskew = 1'b1;
    endtask

    task automatic test_valid_enable();
        set_identity();
        go_capture();
        drive_am();
        bus.i_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (done !== 1'b0 || bus.o_am_flag !== 1'b0 || id_err !== 1'b0) begin
            errors++; $display("FAIL novalid_ignored: got done=%b am=%b err=%b want 000", done, bus.o_am_flag, id_err); end
        drive_am(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL novalid_no_progress: got %b want 0", done); end
        drive_am(); tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL novalid_lock: got %b want 1", done); end
        drive_data(5); tick();
        enable = 1'b0;
        deskew = 1'b0;
        drive_am(); tick();
        drive_data(6); tick();
        checks++; if (bus.o_data !== exp_data(5)) begin errors++; $display("FAIL enable_data_hold: got %h want %h", bus.o_data, exp_data(5)); end
        checks++; if (done !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_am_flag !== 1'b0) begin
            errors++; $display("FAIL enable_ctrl_hold: got done=%b valid=%b am=%b want 1 1 0", done, bus.o_valid, bus.o_am_flag); end
        enable = 1'b1;
        deskew = 1'b1;
        drive_data(7); tick();
        checks++; if (bus.o_data !== exp_data(7)) begin errors++; $display("FAIL enable_resume: got %h want %h", bus.o_data, exp_data(7)); end
        bus.i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_swap();
        test_duplicate();
        test_loss();
        test_midstream();
        test_valid_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_reorder.md
Name: lane_reorder

Overview:
- Sits directly downstream of the deskew stage and consumes its tagged per-lane bus, which carries one start-of-lane tag plus one 66-bit block per lane.
- On alignment-marker (AM) cycles it identifies each physical lane's logical lane ID by matching the AM pattern against the 100GBASE-R table.
- It builds a physical-to-logical map, confirms that map over consecutive AM sets, then outputs the blocks in logical lane order to the AM-removal stage.

Parameters:
- N_LANES, 20, number of PCS lanes.
- NB_DATA, 66, block width per lane.
- NB_FIFO_DATA, 67, tagged width per lane: bit 66 is the start-of-lane tag, bits [65:0] are the block.
- NB_ID, 5, lane ID width; must satisfy 2^NB_ID >= N_LANES.
- N_CONFIRM, 2, number of consecutive identical AM sets required to lock.
- MAX_MISS, 3, number of consecutive bad AM sets while LOCKED that force relock.

Ports:
- i_clock, in, 1, core clock.
- i_reset, in, 1, asynchronous, active-low reset.
- i_enable, in, 1, block enable; when low, all state holds.
- i_valid, in, 1, input data valid; logic advances only when i_valid=1.
- i_deskew_done, in, 1, level from deskew; low means the input is not aligned.
- i_data, in, NB_FIFO_DATA*N_LANES, tagged lanes. Lane 0 occupies the MSBs: lane p = [N_LANES*67-p*67-1 -: 67].
- o_data, out, NB_DATA*N_LANES, reordered blocks with the tag stripped. Logical lane 0 occupies the MSBs.
- o_am_flag, out, 1, the current output cycle is an AM set.
- o_valid, out, 1, registered copy of i_valid gated by LOCKED.
- o_reorder_done, out, 1, high in LOCKED.
- o_id_error, out, 1, one-cycle pulse on an unmatched or duplicate ID set.

Behaviour:
- Reset (i_reset=0): FSM goes to WAIT_DESKEW. o_data=0, o_am_flag=0, o_valid=0, o_reorder_done=0, o_id_error=0. Map cleared, confirm and miss counters cleared.
- AM set event: i_valid & i_enable & (all start tags =1).
  - A partial tag set (some tags high, not all) is an error event; it never counts as an AM set.
- Per-lane ID decode (combinational):
  - Compare block bits [63:40] ({M0,M1,M2}) against AM_TABLE[k] for k=0..N_LANES-1.
  - Match gives id=k. No match flags the lane as unmatched.
  - Sync header bits [65:64] must equal 2'b10, otherwise the lane is unmatched.
- Set validity: every lane matched AND the OR of one-hot(id) across lanes equals all-ones (no duplicates).
- FSM states and transitions:
  - WAIT_DESKEW → CAPTURE when i_deskew_done=1.
  - CAPTURE, on a valid AM set: load candidate map with map[id_p]=p, set confirm count to 1, go to CONFIRM. If N_CONFIRM=1, go straight to LOCKED instead.
  - CAPTURE, on an invalid set: pulse o_id_error, stay in CAPTURE.
  - CONFIRM, on a valid set equal to the candidate map: increment confirm; when confirm reaches N_CONFIRM, go to LOCKED.
  - CONFIRM, on a valid set with a differing map: reload the map, confirm=1.
  - CONFIRM, on an invalid set: pulse o_id_error, return to CAPTURE.
  - LOCKED, on a valid set equal to the map: miss=0.
  - LOCKED, on a bad or differing set: pulse o_id_error, miss+1. When miss reaches MAX_MISS, go to CAPTURE and deassert done in the same cycle as the transition. The map is not updated while LOCKED.
  - Any state: i_deskew_done=0 goes to WAIT_DESKEW and clears counters. This has priority over all other transitions.
- Datapath:
  - One-cycle registered latency: o_data logical lane k = i_data lane map[k] [65:0].
  - o_am_flag = registered AM-set event.
  - Outside LOCKED, o_data holds its last value and o_valid=0.
- i_enable=0: all registers hold, including outputs.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: LANE_REORDER_MAP_OUT_EN.
- Defined: adds output port o_lane_map, NB_ID*N_LANES wide, registered, equal to the current map. Logical lane 0 field occupies the MSBs. Reset value 0.
- Undefined: the port is absent and there is no map-export logic. Reorder behaviour is identical in both cases.

Decomposition:
- Package pcs_am_pkg:
  - AM_TABLE, 20×24-bit {M0,M1,M2} constants per IEEE 802.3 Clause 82.
  - SH_CTRL = 2'b10.
  - FSM state enum: WAIT_DESKEW, CAPTURE, CONFIRM, LOCKED.
- Sub-module am_id_decoder:
  - One 67-bit lane in; outputs id[NB_ID-1:0] and matched.
  - Purely combinational; instantiated N_LANES times in a generate loop.

Test Plan:
1. Identity lane order: deskew_done=1, physical lane p carries the AM for ID p, two AM sets → o_reorder_done=1 one cycle after the 2nd set. Following data is passed unchanged with 1-cycle latency.
2. Swapped lanes: physical 0 carries ID 7 and physical 7 carries ID 0; lock → logical lane 0 output equals physical lane 7 data, e.g. 66'h2_DEAD_BEEF_0000_0001.
3. Duplicate ID: lanes 3 and 4 both carry ID 3 → o_id_error pulses and the FSM stays in CAPTURE with done=0.
4. Loss while LOCKED: three consecutive corrupted AM sets (lane 5 M0 flipped) → o_id_error pulses 3 times; done drops after the 3rd. A good set between bad sets resets miss to 0.
5. Midstream events:
   - Async reset asserted in LOCKED → all outputs 0 immediately.
   - i_deskew_done deasserted in LOCKED → WAIT_DESKEW, done=0 on the next edge.
6. i_valid=0 on AM cycles → AM cycles are ignored and there is no progress toward lock. i_enable=0 → outputs frozen.
